channel_serializer: RTL and testbench

//  Downstream consumer of the channel sequencer FSM (selection/SL/rst). On each SL pulse it captures
//  the magnitude word of the currently selected spectrogram channel from a packed bus into a shift

---
 rtl/channel_serializer.sv | 114 +++++++++++
 tb/tb_channel_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/channel_serializer.sv
// Channel serializer: on each sl strobe, captures the selected channel word and shifts it out
// MSB-first with valid/word/frame markers. It also counts words per frame and flags overlapping loads.
module channel_serializer #(
  parameter int N_CH  = 16,
  parameter int W     = 12,
  parameter int SEL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] ch_data,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sl,
  input  logic              frame_rst,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_start,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overrun,
  output logic [4:0]        word_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam int         CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [4:0] CNT_MAX = 5'd31;

  logic [0:0]    r_state;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_bit_cnt;   // bits still to follow the one currently on ser_out
  logic          r_ser_valid;
  logic          r_word_start;
  logic          r_frame_start;
  logic          r_frame_done;
  logic          r_frame_err;
  logic          r_overrun;
  logic [4:0]    r_word_cnt;

  logic [W-1:0]  w_word;
  logic          w_sel_zero;
  logic          w_overrun_hit;

  // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) w_word = ch_data[k*W +: W];
    end
  end

  assign w_sel_zero    = (sel == '0);
  assign w_overrun_hit = sl && (r_state == S_SHIFT) && (r_bit_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_ser_valid   <= 1'b0;
      r_word_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_word_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (sl) begin
        r_state       <= S_SHIFT;
        r_shift       <= w_word;
        r_bit_cnt     <= CW'(W - 1);
        r_ser_valid   <= 1'b1;
        r_word_start  <= 1'b1;
        r_frame_start <= w_sel_zero;
        if (w_overrun_hit) r_overrun <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        if (r_bit_cnt == '0) begin
          r_state     <= S_IDLE;
          r_shift     <= '0;
          r_ser_valid <= 1'b0;
        end else begin
          r_shift   <= {r_shift[W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - CW'(1);
        end
      end
    end
  end

  // Frame bookkeeping runs independently of the shifter; a frame_rst never disturbs a word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_frame_done <= frame_rst && (r_word_cnt == 5'(N_CH));
      r_frame_err  <= frame_rst && (r_word_cnt != 5'(N_CH));
      if (frame_rst)
        r_word_cnt <= sl ? 5'd1 : 5'd0;
      else if (sl && (r_word_cnt != CNT_MAX))
        r_word_cnt <= r_word_cnt + 5'd1;
    end
  end

  assign ser_out     = r_shift[W-1];
  assign ser_valid   = r_ser_valid;
  assign word_start  = r_word_start;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_channel_serializer.sv
// Bench for channel_serializer: directed scenarios plus randomized sl/sel/frame_rst traffic,
// checked every cycle against a queue-based model of the expected serial stream.
module tb_channel_serializer;

  localparam int N_CH  = 16;
  localparam int W     = 12;
  localparam int SEL_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH*W-1:0] ch_data;
  logic [SEL_W-1:0]  sel;
  logic              sl;
  logic              frame_rst;
  logic              ser_out, ser_valid, word_start, frame_start;
  logic              frame_done, frame_err, overrun;
  logic [4:0]        word_cnt;

  channel_serializer #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_data     (ch_data),
    .sel         (sel),
    .sl          (sl),
    .frame_rst   (frame_rst),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .word_start  (word_start),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .word_cnt    (word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each load replaces the pending stream with the W bits of the chosen word.
  typedef struct packed {
    logic b;
    logic v;
    logic ws;
    logic fs;
  } sbit_t;

  sbit_t m_q[$];
  sbit_t m_cur;
  logic  m_fd, m_fe, m_ov;
  int    m_cnt;

  wire [11:0] obs_vec = {ser_out, ser_valid, word_start, frame_start,
                         frame_done, frame_err, overrun, word_cnt};

  function automatic logic [11:0] exp_vec();
    return {m_cur.b, m_cur.v, m_cur.ws, m_cur.fs, m_fd, m_fe, m_ov, 5'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur = '0;
    m_fd  = 1'b0;
    m_fe  = 1'b0;
    m_ov  = 1'b0;
    m_cnt = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, check all outputs after the edge.
  task automatic step(input logic s, input logic [SEL_W-1:0] sv, input logic fr);
    logic [N_CH*W-1:0] tmp;
    logic [W-1:0]      word;
    sl        = s;
    sel       = sv;
    frame_rst = fr;
    if (fr) begin
      m_fd  = (m_cnt == N_CH);
      m_fe  = (m_cnt != N_CH);
      m_cnt = s ? 1 : 0;
    end else begin
      m_fd = 1'b0;
      m_fe = 1'b0;
      if (s && m_cnt < 31) m_cnt++;
    end
    if (s) begin
      if (m_q.size() > 0) m_ov = 1'b1;
      m_q.delete();
      tmp  = ch_data >> (int'(sv) * W);
      word = (int'(sv) < N_CH) ? tmp[W-1:0] : '0;
      for (int i = W - 1; i >= 0; i--)
        m_q.push_back('{word[i], 1'b1, (i == W - 1), (i == W - 1) && (sv == '0)});
    end
    if (m_q.size() > 0) m_cur = m_q.pop_front();
    else                m_cur = '0;
    @(posedge clk);
    #1;
    check("cycle", 32'(obs_vec), 32'(exp_vec()));
    sl        = 1'b0;
    frame_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic send_word(input logic [SEL_W-1:0] sv);
    step(1'b1, sv, 1'b0);
    idle(W - 1);
  endtask

  logic [W-1:0] bits;
  int           run, fs_cnt, ws_cnt, gap;

  initial begin
    rst_n     = 1'b0;
    sl        = 1'b0;
    sel       = '0;
    frame_rst = 1'b0;
    for (int k = 0; k < N_CH; k++) ch_data[k*W +: W] = W'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_state", 32'(obs_vec), 32'd0);

    // Single word from channel 3.
    ch_data[3*W +: W] = 12'hA5C;
    bits   = '0;
    ws_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < W; i++) begin
      step(i == 0, 4'd3, 1'b0);
      bits   = {bits[W-2:0], ser_out};
      ws_cnt += int'(word_start);
      fs_cnt += int'(frame_start);
    end
    check("t2_bits", 32'(bits), 32'h0000_0A5C);
    check("t2_word_start", 32'(ws_cnt), 32'd1);
    check("t2_frame_start", 32'(fs_cnt), 32'd0);
    idle(1);
    check("t2_valid_low", 32'(ser_valid), 32'd0);
    step(1'b0, '0, 1'b1);  // clear word count

    // Full frame with back-to-back words.
    for (int k = 0; k < N_CH; k++) ch_data[k*W +: W] = W'($urandom);
    run    = 0;
    fs_cnt = 0;
    for (int j = 0; j < N_CH; j++) begin
      for (int i = 0; i < W; i++) begin
        step(i == 0, SEL_W'(j), 1'b0);
        run    += int'(ser_valid);
        fs_cnt += int'(frame_start);
      end
    end
    check("t3_valid_run", 32'(run), 32'd192);
    check("t3_frame_start", 32'(fs_cnt), 32'd1);
    check("t3_word_cnt", 32'(word_cnt), 32'd16);
    step(1'b0, '0, 1'b1);
    check("t3_done", 32'({frame_done, frame_err, overrun}), 32'b100);
    check("t3_cnt_clr", 32'(word_cnt), 32'd0);

    // 16 words, then sl and frame_rst together.
    for (int j = 0; j < N_CH; j++) send_word(SEL_W'($urandom));
    step(1'b1, 4'd5, 1'b1);
    check("t6_done", 32'({frame_done, frame_err}), 32'b10);
    check("t6_cnt", 32'(word_cnt), 32'd1);
    idle(W);
    step(1'b0, '0, 1'b1);

    // Short frame of 10 words.
    for (int j = 0; j < 10; j++) send_word(SEL_W'($urandom));
    step(1'b0, '0, 1'b1);
    check("t5_err", 32'({frame_done, frame_err}), 32'b01);
    check("t5_cnt", 32'(word_cnt), 32'd0);

    // Reload while the 5th bit is on the line.
    step(1'b1, 4'd7, 1'b0);
    idle(4);
    check("t4_no_ovr_yet", 32'(overrun), 32'd0);
    step(1'b1, 4'd9, 1'b0);
    check("t4_overrun", 32'({overrun, word_start, ser_valid}), 32'b111);
    idle(2 * W);
    check("t4_sticky", 32'(overrun), 32'd1);

    // Randomized traffic.
    gap = 0;
    for (int c = 0; c < 1500; c++) begin
      if (($urandom % 50) == 0) ch_data[($urandom % N_CH)*W +: W] = W'($urandom);
      if (gap == 0) begin
        gap = (($urandom % 10) < 7) ? W : int'($urandom_range(1, 20));
        step(1'b1, SEL_W'($urandom), (($urandom % 30) == 0));
      end else begin
        step(1'b0, SEL_W'($urandom), (($urandom % 60) == 0));
      end
      gap--;
    end

    // Asynchronous reset in the middle of a word.
    step(1'b1, 4'd0, 1'b0);
    idle(3);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs_vec), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_release", 32'(obs_vec), 32'd0);
    send_word(4'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
